// File: rtl/bcd_button_accumulator_pkg.sv
// Shared types and helpers for the digit-serial BCD button accumulator.
package bcd_acc_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD    = 2'd1,
        ST_COMMIT = 2'd2
    } acc_state_t;

    function automatic logic is_bcd(input logic [BCD_DIGIT_W-1:0] nibble);
        return (nibble <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with carry in/out.
module bcd_digit_add
    import bcd_acc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] sum,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        sum  = raw[BCD_DIGIT_W-1:0];
        cout = 1'b0;
        // Decimal correction: skipping the six unused codes wraps back into 0..9.
        if (raw > {1'b0, BCD_MAX_DIGIT}) begin
            sum  = raw[BCD_DIGIT_W-1:0] + 4'd6;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_button_accumulator.sv
// Packed-BCD accumulator with digit-serial adds and atomic commit.
// Define BCD_ACC_SATURATE_EN to clamp to all nines on overflow instead of wrapping.
module bcd_button_accumulator
    import bcd_acc_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int NUM_BTN = 4,
    parameter logic [NUM_BTN*4*DIGITS-1:0] BTN_STEP = {16'h0550, 16'h0200, 16'h0180, 16'h0010},
    parameter logic [4*DIGITS-1:0] PRESET_A = 16'h0010,
    parameter logic [4*DIGITS-1:0] PRESET_B = 16'h0205
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BTN-1:0]    btn,
    input  logic                  load_a,
    input  logic                  load_b,
    input  logic [4*DIGITS-1:0]   y_in,
    input  logic                  y_add,
    output logic [4*DIGITS-1:0]   acc_out,
    output logic                  busy,
    output logic                  done,
    output logic                  carry,
    output logic                  invalid
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{BCD_MAX_DIGIT}};

    acc_state_t         state_q, state_d;
    logic [NUM_BTN-1:0] btn_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   op_q, op_d;
    logic [ACC_W-1:0]   work_q, work_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cy_q, cy_d;
    logic               carry_q, carry_d;
    logic               invalid_q, invalid_d;

    logic [NUM_BTN-1:0]     press;
    logic                   btn_hit;
    logic [ACC_W-1:0]       btn_operand;
    logic [ACC_W-1:0]       operand;
    logic [DIGITS-1:0]      nib_ok;
    logic                   operand_ok;
    logic [ACC_W-1:0]       load_val;
    logic [ACC_W-1:0]       work_shift;
    logic [BCD_DIGIT_W-1:0] sum_digit;
    logic                   sum_cout;
    logic                   overflow;

    assign press = btn & ~btn_q;

    // Descending scan so the lowest-index press is the one left standing.
    always_comb begin
        btn_hit     = 1'b0;
        btn_operand = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press[i]) begin
                btn_hit     = 1'b1;
                btn_operand = BTN_STEP[i*ACC_W +: ACC_W];
            end
        end
    end

    assign operand = y_add ? y_in : btn_operand;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_chk
        assign nib_ok[gi] = is_bcd(operand[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    assign operand_ok = &nib_ok;

    assign load_val = (load_a && load_b) ? '0 : (load_a ? PRESET_A : PRESET_B);

    bcd_digit_add u_digit_add (
        .a    (work_q[BCD_DIGIT_W-1:0]),
        .b    (op_q[BCD_DIGIT_W-1:0]),
        .cin  (cy_q),
        .sum  (sum_digit),
        .cout (sum_cout)
    );

    assign overflow = (state_q == ST_ADD) && (idx_q == IDX_W'(DIGITS - 1)) && sum_cout;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        op_d      = op_q;
        work_d    = work_q;
        idx_d     = idx_q;
        cy_d      = cy_q;
        carry_d   = carry_q;
        invalid_d = 1'b0;

        // Finished digits enter at the top so after DIGITS steps the sum is in place.
        work_shift = work_q >> BCD_DIGIT_W;
        work_shift[ACC_W-1 -: BCD_DIGIT_W] = sum_digit;

        if (load_a || load_b) begin
            acc_d   = load_val;
            carry_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (y_add || btn_hit) begin
                        if (operand_ok) begin
                            op_d    = operand;
                            work_d  = acc_q;
                            idx_d   = '0;
                            cy_d    = 1'b0;
                            state_d = ST_ADD;
                        end else begin
                            invalid_d = 1'b1;
                        end
                    end
                end
                ST_ADD: begin
                    work_d = work_shift;
                    op_d   = op_q >> BCD_DIGIT_W;
                    cy_d   = sum_cout;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        state_d = ST_COMMIT;
                        carry_d = carry_q | overflow;
`ifdef BCD_ACC_SATURATE_EN
                        acc_d   = overflow ? ALL_NINES : work_shift;
`else
                        acc_d   = work_shift;
`endif
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // Buttons track even in reset so a held press cannot fire on release of reset.
        btn_q <= btn;
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            op_q      <= '0;
            work_q    <= '0;
            idx_q     <= '0;
            cy_q      <= 1'b0;
            carry_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            work_q    <= work_d;
            idx_q     <= idx_d;
            cy_q      <= cy_d;
            carry_q   <= carry_d;
            invalid_q <= invalid_d;
        end
    end

    assign acc_out = acc_q;
    assign busy    = (state_q == ST_ADD);
    assign done    = (state_q == ST_COMMIT);
    assign carry   = carry_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_button_accumulator.sv
// Self-checking bench: vector table plus hand sequences, add results scored through a queue.
module tb_bcd_button_accumulator;

`ifdef BCD_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic        load_a, load_b;
    logic [15:0] y_in;
    logic        y_add;
    logic [15:0] acc_out;
    logic        busy, done, carry, invalid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] acc;
        logic        carry;
    } exp_t;
    exp_t sb_q[$];

    typedef struct packed {
        logic [3:0]  btn;
        logic        la;
        logic        lb;
        logic [15:0] y;
        logic        ya;
        logic [15:0] exp_acc;
        logic        exp_carry;
        logic        exp_inv;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    bcd_button_accumulator dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .load_a  (load_a),
        .load_b  (load_b),
        .y_in    (y_in),
        .y_add   (y_add),
        .acc_out (acc_out),
        .busy    (busy),
        .done    (done),
        .carry   (carry),
        .invalid (invalid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s: %h", name, act);
        end
    endtask

    // Scoreboard: every commit must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(acc_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_acc", 32'(acc_out), 32'(e.acc));
                check("sb_carry", 32'(carry), 32'(e.carry));
            end
        end
    end

    task automatic release_inputs();
        btn    = '0;
        load_a = 1'b0;
        load_b = 1'b0;
        y_add  = 1'b0;
    endtask

    // Called at the negedge one cycle after acceptance; returns there after done.
    task automatic wait_done(input logic [15:0] hold_acc, output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            if (acc_out !== hold_acc) check("acc_atomic", 32'(acc_out), 32'(hold_acc));
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(cyc < 20), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input logic [15:0] prev_acc);
        int cyc, nbusy;
        @(negedge clk);
        btn    = v.btn;
        load_a = v.la;
        load_b = v.lb;
        y_in   = v.y;
        y_add  = v.ya;
        if (!v.la && !v.lb && !v.exp_inv) sb_q.push_back('{v.exp_acc, v.exp_carry});
        @(negedge clk);
        release_inputs();
        if (v.la || v.lb) begin
            check("load_acc", 32'(acc_out), 32'(v.exp_acc));
            check("load_carry", 32'(carry), 32'(v.exp_carry));
            check("load_busy", 32'(busy), 32'd0);
        end else if (v.exp_inv) begin
            check("inv_pulse", 32'(invalid), 32'd1);
            check("inv_busy", 32'(busy), 32'd0);
            check("inv_acc", 32'(acc_out), 32'(v.exp_acc));
            @(negedge clk);
            check("inv_clear", 32'(invalid), 32'd0);
            check("inv_busy2", 32'(busy), 32'd0);
        end else begin
            wait_done(prev_acc, cyc, nbusy);
            check("add_latency", 32'(cyc), 32'd4);
            check("add_busy_cycles", 32'(nbusy), 32'd4);
            @(negedge clk);
            check("post_done_idle", 32'({done, busy}), 32'd0);
        end
    endtask

    initial begin
        int cyc, nbusy;
        logic [15:0] prev;

        //               btn     la    lb    y         ya    exp_acc                      c     inv
        vecs[0]  = '{4'b1000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0550,                    1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0205,                    1'b0, 1'b0};
        vecs[2]  = '{4'b0100, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0405,                    1'b0, 1'b0};
        vecs[3]  = '{4'b0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0585,                    1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1135,                    1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0010,                    1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 1'b0, 1'b0, 16'h9990, 1'b1, SAT ? 16'h9999 : 16'h0000,   1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0010,                    1'b0, 1'b0};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 16'h00A1, 1'b1, 16'h0010,                    1'b0, 1'b1};
        vecs[9]  = '{4'b0000, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h1244,                    1'b0, 1'b0};
        vecs[10] = '{4'b1001, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1254,                    1'b0, 1'b0};
        vecs[11] = '{4'b0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000,                    1'b0, 1'b0};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 16'h9999, 1'b1, 16'h9999,                    1'b0, 1'b0};
        vecs[13] = '{4'b0001, 1'b0, 1'b0, 16'h0000, 1'b0, SAT ? 16'h9999 : 16'h0009,   1'b1, 1'b0};
        vecs[14] = '{4'b1000, 1'b0, 1'b0, 16'h0001, 1'b1, SAT ? 16'h9999 : 16'h0010,   1'b1, 1'b0};
        vecs[15] = '{4'b0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0205,                    1'b0, 1'b0};

        // Reset with btn[3] held: the held level must not fire afterwards.
        reset = 1'b1;
        release_inputs();
        y_in = '0;
        btn  = 4'b1000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_acc", 32'(acc_out), 32'h0);
        check("rst_flags", 32'({busy, done, carry, invalid}), 32'h0);
        repeat (4) @(negedge clk);
        check("held_btn_no_fire", 32'(busy), 32'd0);
        btn = '0;
        repeat (2) @(negedge clk);

        prev = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], prev);
            prev = vecs[i].exp_acc;
        end

        // Press while busy is dropped: only +0010 lands.
        @(negedge clk);
        btn = 4'b0001;
        sb_q.push_back('{16'h0215, 1'b0});
        @(negedge clk);
        btn = 4'b0000;
        @(negedge clk);
        btn = 4'b1000;
        @(negedge clk);
        btn = 4'b0000;
        wait_done(16'h0205, cyc, nbusy);
        repeat (8) begin
            @(negedge clk);
            if (busy) check("busy_press_dropped", 32'(busy), 32'd0);
        end
        check("busy_press_acc", 32'(acc_out), 32'h0215);

        // load_a mid-ADD aborts without a done pulse.
        @(negedge clk);
        btn = 4'b1000;
        @(negedge clk);
        btn = 4'b0000;
        check("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        check("abort_acc", 32'(acc_out), 32'h0010);
        check("abort_busy_drop", 32'(busy), 32'd0);
        repeat (6) begin
            @(negedge clk);
            if (done) check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_acc_stable", 32'(acc_out), 32'h0010);

        // Set carry, then reset mid-ADD.
        @(negedge clk);
        y_in  = 16'h9990;
        y_add = 1'b1;
        sb_q.push_back('{SAT ? 16'h9999 : 16'h0000, 1'b1});
        @(negedge clk);
        y_add = 1'b0;
        wait_done(16'h0010, cyc, nbusy);
        @(negedge clk);
        check("ovf_carry", 32'(carry), 32'd1);
        btn = 4'b0001;
        @(negedge clk);
        btn = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_acc", 32'(acc_out), 32'h0);
        check("midrst_flags", 32'({busy, done, carry, invalid}), 32'h0);
        repeat (6) @(negedge clk);
        check("midrst_idle", 32'(busy), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
